// File: rtl/alu_sequencer.sv
// alu_sequencer: command-driven initiator for an external combinational ALU.
// Holds a 4-entry register file and an NZCV status register, registers the
// ALU operand/control inputs, captures the ALU result and flags, and returns
// each result over a valid/ready response channel.
// Optional feature macro: ALU_SEQ_CARRY_CHAIN_EN, which routes the stored C
// flag into an add as carry-in when the command asks for it.
module alu_sequencer #(
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load,
  input  logic [2:0]        cmd_op,
  input  logic [1:0]        cmd_rd,
  input  logic [1:0]        cmd_ra,
  input  logic [1:0]        cmd_rb,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic              cmd_use_carry,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_control,
  output logic              alu_carryin,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_v,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_flags
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam logic [2:0] OP_ADD = 3'd0;

  logic [1:0]        state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic [DATA_W-1:0] rf_q [4];
  logic [DATA_W-1:0] rf_d [4];
  logic [3:0]        nzcv_q, nzcv_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [2:0]        alu_ctl_q, alu_ctl_d;
  logic              alu_cin_q, alu_cin_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic [1:0]        rd_q, rd_d;
  logic [2:0]        op_q, op_d;
  logic              cin_sel;

`ifdef ALU_SEQ_CARRY_CHAIN_EN
  assign cin_sel = cmd_use_carry & (cmd_op == OP_ADD) & nzcv_q[1];
`else
  // Carry chaining is compiled out; the request bit is deliberately ignored.
  logic unused_use_carry;
  assign unused_use_carry = cmd_use_carry;
  assign cin_sel          = 1'b0;
`endif

  // Next-state, register-file and ALU-interface update for the three-state sequencer
  always_comb begin
    state_d      = state_q;
    rf_d         = rf_q;
    nzcv_d       = nzcv_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctl_d    = alu_ctl_q;
    alu_cin_d    = alu_cin_q;
    rsp_result_d = rsp_result_q;
    rd_d         = rd_q;
    op_d         = op_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          rd_d = cmd_rd;
          op_d = cmd_op;
          if (cmd_load) begin
            rf_d[cmd_rd] = cmd_imm;
            rsp_result_d = cmd_imm;
            state_d      = S_RESP;
          end else begin
            // Operands come from the current file contents, so rd==ra/rb sees the old value.
            alu_a_d   = rf_q[cmd_ra];
            alu_b_d   = rf_q[cmd_rb];
            alu_ctl_d = cmd_op;
            alu_cin_d = cin_sel;
            state_d   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        rf_d[rd_q]   = alu_result;
        rsp_result_d = alu_result;
        // Only add defines a meaningful carry; other ops keep the stored C.
        nzcv_d       = {alu_n, alu_z, (op_q == OP_ADD) ? alu_c : nzcv_q[1], alu_v};
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    cmd_ready_d = (state_d == S_IDLE);
  end

  // State and datapath registers; reset abandons any in-flight command
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cmd_ready_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        rf_q[i] <= '0;
      end
      nzcv_q       <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctl_q    <= '0;
      alu_cin_q    <= 1'b0;
      rsp_result_q <= '0;
      rd_q         <= '0;
      op_q         <= '0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      rf_q         <= rf_d;
      nzcv_q       <= nzcv_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctl_q    <= alu_ctl_d;
      alu_cin_q    <= alu_cin_d;
      rsp_result_q <= rsp_result_d;
      rd_q         <= rd_d;
      op_q         <= op_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_control = alu_ctl_q;
  assign alu_carryin = alu_cin_q;
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_result  = rsp_result_q;
  assign rsp_flags   = nzcv_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench for alu_sequencer with a behavioural
// 3-bit ALU attached to its ALU port. Honors ALU_SEQ_CARRY_CHAIN_EN.
module tb_alu_sequencer;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready, cmd_load, cmd_use_carry;
  logic [2:0]   cmd_op;
  logic [1:0]   cmd_rd, cmd_ra, cmd_rb;
  logic [W-1:0] cmd_imm;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [2:0]   alu_control;
  logic         alu_carryin, alu_n, alu_z, alu_c, alu_v;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_result;
  logic [3:0]   rsp_flags;

  typedef struct packed {
    logic [W-1:0] res;
    logic [3:0]   fl;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m_rf [4];
  logic [3:0]   m_nzcv;
  int           checks = 0;
  int           errors = 0;

  alu_sequencer #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .cmd_imm(cmd_imm), .cmd_use_carry(cmd_use_carry),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_carryin(alu_carryin),
    .alu_result(alu_result), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags)
  );

  always #5 clk = ~clk;

  // Reference ALU: returns {carry, overflow, result}
  function automatic logic [W+1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op, input logic cin);
    logic [W:0]   sum;
    logic [W-1:0] r;
    logic         c, v;
    c = 1'b0;
    v = 1'b0;
    r = '0;
    case (op)
      3'd0: begin
        sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        r = sum[W-1:0];
        c = sum[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'd1: r = a << b;
      3'd2: r = a >> b;
      3'd3: r = a ^ b;
      3'd4: r = a | b;
      3'd5: r = ~a;
      3'd6: r = a & b;
      default: begin
        sum = {1'b0, a} - {1'b0, b};
        r = sum[W-1:0];
        c = sum[W];
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
    endcase
    return {c, v, r};
  endfunction

  logic [W+1:0] alu_out;
  always_comb begin
    alu_out    = alu_ref(alu_a, alu_b, alu_control, alu_carryin);
    alu_result = alu_out[W-1:0];
    alu_v      = alu_out[W];
    alu_c      = alu_out[W+1];
    alu_n      = alu_out[W-1];
    alu_z      = (alu_out[W-1:0] == '0);
  end

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = '0;
    m_nzcv = 4'b0000;
  endtask

  // Drive one command, push its expected response, check ALU drive and latency
  task automatic do_cmd(input logic load, input logic [2:0] op, input logic [1:0] rd,
                        input logic [1:0] ra, input logic [1:0] rb,
                        input logic [W-1:0] imm, input logic uc);
    exp_t         e;
    logic [W-1:0] a, b;
    logic         cin;
    logic [W+1:0] o;
    int           k;
    int           lat;
    a = m_rf[ra];
    b = m_rf[rb];
`ifdef ALU_SEQ_CARRY_CHAIN_EN
    cin = uc && (op == 3'd0) && m_nzcv[1];
`else
    cin = 1'b0;
`endif
    if (load) begin
      m_rf[rd] = imm;
      e.res = imm;
    end else begin
      o = alu_ref(a, b, op, cin);
      m_rf[rd] = o[W-1:0];
      m_nzcv = {o[W-1], o[W-1:0] == '0, (op == 3'd0) ? o[W+1] : m_nzcv[1], o[W]};
      e.res = o[W-1:0];
    end
    e.fl = m_nzcv;
    sb.push_back(e);

    cmd_load = load; cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb;
    cmd_imm = imm; cmd_use_carry = uc; cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL cmd_accept_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, k);
      cmd_valid = 1'b0;
      void'(sb.pop_back());
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    if (!load) begin
      checks++;
      if ({alu_a, alu_b, alu_control, alu_carryin} !== {a, b, op, cin}) begin
        errors++;
        $display("FAIL alu_drive: a=%0d b=%0d ctl=%0d cin=%b, required a=%0d b=%0d ctl=%0d cin=%b",
                 alu_a, alu_b, alu_control, alu_carryin, a, b, op, cin);
      end
    end
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== (load ? 1 : 2) || !rsp_valid) begin
      errors++;
      $display("FAIL rsp_latency: %0d cycles (valid=%b), required %0d", lat, rsp_valid, load ? 1 : 2);
    end
  endtask

  // Pop the scoreboard, compare the response, then consume it
  task automatic get_rsp(output logic [W-1:0] res, output logic [3:0] fl);
    exp_t e;
    res = rsp_result;
    fl  = rsp_flags;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: response %0d with no expected entry", rsp_result);
    end else begin
      e = sb.pop_front();
      if (rsp_valid !== 1'b1 || rsp_result !== e.res || rsp_flags !== e.fl) begin
        errors++;
        $display("FAIL rsp_data: valid=%b result=%0d flags=%b, required valid=1 result=%0d flags=%b",
                 rsp_valid, rsp_result, rsp_flags, e.res, e.fl);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rsp_release: rsp_valid=%b cmd_ready=%b, required 0 and 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_ra = '0; cmd_rb = '0;
    cmd_imm = '0; cmd_use_carry = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if ({cmd_ready, rsp_valid, alu_a, alu_b, alu_control, alu_carryin, rsp_result, rsp_flags} !== '0) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b a=%0d b=%0d ctl=%0d cin=%b res=%0d fl=%b, required all 0",
               cmd_ready, rsp_valid, alu_a, alu_b, alu_control, alu_carryin, rsp_result, rsp_flags);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: cmd_ready=%b, required 1", cmd_ready);
    end
  endtask

  task automatic test_add();
    logic [W-1:0] r;
    logic [3:0]   f;
    do_cmd(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 3'd3, 1'b0); get_rsp(r, f);
    do_cmd(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 3'd2, 1'b0); get_rsp(r, f);
    do_cmd(1'b0, 3'd0, 2'd2, 2'd0, 2'd1, 3'd0, 1'b0); get_rsp(r, f);
    checks++;
    if (r !== 3'd5 || f !== 4'b1001) begin
      errors++;
      $display("FAIL add_3_2: result=%0d flags=%b, required 5 and 1001", r, f);
    end
  endtask

  task automatic test_sub();
    logic [W-1:0] r;
    logic [3:0]   f;
    do_cmd(1'b0, 3'd7, 2'd3, 2'd0, 2'd0, 3'd0, 1'b0); get_rsp(r, f);
    checks++;
    if (r !== 3'd0 || f !== 4'b0100) begin
      errors++;
      $display("FAIL sub_self: result=%0d flags=%b, required 0 and 0100", r, f);
    end
  endtask

  task automatic test_carry_chain();
    logic [W-1:0] r;
    logic [3:0]   f;
    do_cmd(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 3'd7, 1'b0); get_rsp(r, f);
    do_cmd(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 3'd1, 1'b0); get_rsp(r, f);
    do_cmd(1'b0, 3'd0, 2'd2, 2'd0, 2'd1, 3'd0, 1'b0); get_rsp(r, f);
    checks++;
    if (r !== 3'd0 || f !== 4'b0110) begin
      errors++;
      $display("FAIL add_wrap: result=%0d flags=%b, required 0 and 0110", r, f);
    end
    do_cmd(1'b0, 3'd0, 2'd3, 2'd0, 2'd1, 3'd0, 1'b1); get_rsp(r, f);
    checks++;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
    if (r !== 3'd1 || f !== 4'b0010) begin
      errors++;
      $display("FAIL add_carry_chain: result=%0d flags=%b, required 1 and 0010", r, f);
    end
`else
    if (r !== 3'd0 || f !== 4'b0110) begin
      errors++;
      $display("FAIL add_carry_ignored: result=%0d flags=%b, required 0 and 0110", r, f);
    end
`endif
  endtask

  task automatic test_resp_hold();
    logic [W-1:0] r;
    logic [3:0]   f;
    logic [W-1:0] held_r;
    logic [3:0]   held_f;
    do_cmd(1'b0, 3'd3, 2'd2, 2'd0, 2'd1, 3'd0, 1'b0);
    held_r = sb[0].res;
    held_f = sb[0].fl;
    // A competing load is offered while the response is pending and must be ignored.
    cmd_load = 1'b1; cmd_rd = 2'd0; cmd_imm = 3'd4; cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== held_r || rsp_flags !== held_f || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL resp_hold[%0d]: valid=%b result=%0d flags=%b ready=%b, required 1 %0d %b 0",
                 i, rsp_valid, rsp_result, rsp_flags, cmd_ready, held_r, held_f);
      end
    end
    cmd_valid = 1'b0;
    get_rsp(r, f);
    // r0 must still be 7: or it with r1=1 gives 7.
    do_cmd(1'b0, 3'd4, 2'd2, 2'd0, 2'd1, 3'd0, 1'b0); get_rsp(r, f);
    checks++;
    if (r !== 3'd7) begin
      errors++;
      $display("FAIL ignored_cmd_no_write: result=%0d, required 7", r);
    end
  endtask

  task automatic test_alias();
    logic [W-1:0] r;
    logic [3:0]   f;
    do_cmd(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 3'd5, 1'b0); get_rsp(r, f);
    do_cmd(1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0); get_rsp(r, f);
    checks++;
    if (r !== 3'd2 || f !== 4'b0011) begin
      errors++;
      $display("FAIL alias_add: result=%0d flags=%b, required 2 and 0011", r, f);
    end
    do_cmd(1'b0, 3'd4, 2'd1, 2'd0, 2'd0, 3'd0, 1'b0); get_rsp(r, f);
    checks++;
    if (r !== 3'd2) begin
      errors++;
      $display("FAIL alias_writeback: r0 read as %0d, required 2", r);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] r;
    logic [3:0]   f;
    for (int i = 0; i < 24; i++) begin
      do_cmd(1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)));
      get_rsp(r, f);
    end
  endtask

  task automatic test_reset_in_issue();
    logic [W-1:0] r;
    logic [3:0]   f;
    do_cmd(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 3'd6, 1'b0); get_rsp(r, f);
    cmd_load = 1'b0; cmd_op = 3'd0; cmd_rd = 2'd3; cmd_ra = 2'd1; cmd_rb = 2'd1;
    cmd_use_carry = 1'b0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    checks++;
    if ({cmd_ready, rsp_valid, alu_a, alu_b, alu_control, alu_carryin, rsp_result, rsp_flags} !== '0) begin
      errors++;
      $display("FAIL reset_in_issue: ready=%b valid=%b a=%0d b=%0d ctl=%0d cin=%b res=%0d fl=%b, required all 0",
               cmd_ready, rsp_valid, alu_a, alu_b, alu_control, alu_carryin, rsp_result, rsp_flags);
    end
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_no_response: rsp_valid=%b cmd_ready=%b, required 0 and 1", rsp_valid, cmd_ready);
      end
    end
    do_cmd(1'b0, 3'd4, 2'd2, 2'd1, 2'd3, 3'd0, 1'b0); get_rsp(r, f);
    checks++;
    if (r !== 3'd0 || f !== 4'b0100) begin
      errors++;
      $display("FAIL rf_cleared: result=%0d flags=%b, required 0 and 0100", r, f);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_carry_chain();
    test_resp_hold();
    test_alias();
    test_back_to_back();
    test_reset_in_issue();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-driven initiator for the combinational width-bit ALU. Accepts register-level operations over a valid/ready command channel and holds a 4-entry register file plus an NZCV status register. Drives the ALU operand/control inputs from registers and captures its result and flags. Returns each result on a valid/ready response channel; sits between a test/host controller and the ALU datapath.

## Interface
- width, 3, datapath and register width in bits
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high at clk edge
- cmd_load  in  1  1 = load immediate into rd; 0 = ALU op
- cmd_op  in  3  ALU control: 0 add, 1 sll, 2 srl, 3 xor, 4 or, 5 not, 6 and, 7 sub
- cmd_rd, cmd_ra, cmd_rb  in  2 each  destination, operand A, operand B register index
- cmd_imm  in  width  immediate for load
- cmd_use_carry  in  1  drive stored C as ALU carry-in (add only)
- alu_a, alu_b  out  width  ALU operands, registered
- alu_control  out  3  ALU control, registered
- alu_carryin  out  1  ALU carry-in, registered
- alu_result  in  width  ALU result
- alu_n, alu_z, alu_c, alu_v  in  1 each  ALU flags
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when both high at clk edge
- rsp_result  out  width  value written to rd
- rsp_flags  out  4  {N,Z,C,V} status after the command

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE: cmd_ready=1. On cmd handshake latch all cmd fields. Load -> write rf[rd]=cmd_imm, rsp_result=cmd_imm, flags unchanged, go RESP. ALU op -> register alu_a=rf[ra], alu_b=rf[rb], alu_control=cmd_op, alu_carryin, go ISSUE.
- ISSUE: cmd_ready=0. At end of cycle sample ALU outputs: rf[rd]=alu_result, rsp_result=alu_result; N,Z,V always updated; C updated only when op=0, otherwise held. Go RESP.
- RESP: rsp_valid=1, rsp_result/rsp_flags stable. On rsp_ready go IDLE; rsp_valid drops next cycle.
- alu_carryin = stored C when cmd_use_carry=1 and op=0, else 0.
- ra/rb/rd may alias; operands are read before the write (rd==ra reads old value).
- ALU outputs hold last value outside ISSUE.
- Reset: state IDLE, rf all 0, NZCV=0, alu_a/alu_b/alu_control/alu_carryin=0, rsp_valid=0, rsp_result=0, rsp_flags=0, cmd_ready=0 during the reset cycle and 1 the cycle after. Reset in ISSUE or RESP abandons the command: no rf write, no response.

## Timing
- ALU op: accept edge T; ISSUE cycle T..T+1; rsp_valid=1 from T+2.
- Load: rsp_valid=1 from T+1.
- Minimum op throughput one per 3 cycles; load one per 2 cycles.
- rsp_ready is held for any number of cycles without change to rsp_* or state.
- cmd_valid while cmd_ready=0 is ignored; the command must be held by the sender.
- rf write and flag update occur on the same edge as the RESP entry.

## Configuration
- ALU_SEQ_CARRY_CHAIN_EN defined: cmd_use_carry honored as above (multi-precision add).
- Not defined: cmd_use_carry ignored, alu_carryin always 0; C still captured from add.

## Test plan
- Reset, then load r0=3, r1=2; add r2=r0+r1 -> rsp_result=5, flags N=1 Z=0 C=0 V=1, rsp_valid at T+2.
- sub r3=r0-r0 with r0=3 -> result 0, Z=1, V=0; C unchanged from previous op.
- Load r0=7, r1=1; add r2=r0+r1 -> 0, C=1 Z=1; add r3=r0+r1 with use_carry -> alu_carryin=1, result 1 with macro, 0 without.
- Op with rsp_ready low 4 cycles -> rsp_valid/rsp_result stable, cmd_ready=0, no second command accepted; release -> IDLE next cycle.
- Aliasing: r0=5, add r0=r0+r0 -> operands 5,5, result 2 written to r0, C=1.
- Assert rst during ISSUE -> next cycle all outputs at reset values, rf cleared, no response.
